stable_matching_seq: RTL and testbench

//  Sequential, parametrised Gale-Shapley engine: one proposal per clock instead of the N-stage unrolled combinational array.

---
 rtl/stable_matching_seq.sv | 186 ++++++++++++++++++
 tb/tb_stable_matching_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/stable_matching_seq.sv
// Sequential Gale-Shapley matcher: one proposal per clock, lowest free proposer first.
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | one proposal per edge until no candidate or budget spent
// DONE  | result held; start launches a fresh run
module stable_matching_seq #(
   parameter int S        = 10,
   parameter int R        = 10,
   parameter int Ks       = 10,
   parameter int Kr       = 10,
   parameter int MAX_ITER = S*Ks
) (
   input  logic                                                                  clk,
   input  logic                                                                  rst_n,
   input  logic                                                                  start,
   input  logic [R*Kr*((S>1)?$clog2(S):1)+S*Ks*((R>1)?$clog2(R):1)-1:0]          g,
   output logic                                                                  busy,
   output logic                                                                  done,
   output logic                                                                  timeout,
   output logic [$clog2(MAX_ITER+1)-1:0]                                         iter_count,
   output logic [R*((S>1)?$clog2(S):1)-1:0]                                      o,
   output logic [R-1:0]                                                          r_matched,
   output logic [S-1:0]                                                          s_matched
);
   localparam int LS  = (S > 1) ? $clog2(S) : 1;
   localparam int LR  = (R > 1) ? $clog2(R) : 1;
   localparam int PCW = $clog2(Ks+1);
   localparam int IW  = $clog2(MAX_ITER+1);
   localparam int RW  = R*Kr*LS;
   localparam int SW  = S*Ks*LR;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [SW-1:0]    spref_q, spref_d;
   logic [RW-1:0]    rpref_q, rpref_d;
   logic [S*PCW-1:0] pc_q, pc_d;
   logic [IW-1:0]    iter_q, iter_d;
   logic             timeout_q, timeout_d;
   logic [R*LS-1:0]  o_q, o_d;
   logic [R-1:0]     rm_q, rm_d;
   logic [S-1:0]     sm_q, sm_d;

   logic             cand_found;
   logic [LS-1:0]    cand;
   logic [LR-1:0]    r_sel;
   int               r_idx;
   logic [LS-1:0]    holder;
   logic             r_free;
   int               rank_new, rank_old;
   logic             take, drop;

   always_comb begin
      cand_found = 1'b0;
      cand       = '0;
      for (int i = S-1; i >= 0; i--) begin
         if (pc_q[i*PCW +: PCW] != '0 && !sm_q[i]) begin
            cand_found = 1'b1;
            cand       = LS'(i);
         end
      end
   end

   // Next preference entry of the candidate is index Ks-pc.
   always_comb begin
      r_sel = '0;
      for (int i = 0; i < S; i++) begin
         for (int j = 0; j < Ks; j++) begin
            if (cand == LS'(i) && pc_q[i*PCW +: PCW] == PCW'(Ks-j))
               r_sel = spref_q[(i*Ks+j)*LR +: LR];
         end
      end
      r_idx    = int'(r_sel);
      holder   = '0;
      r_free   = 1'b1;
      rank_new = Kr;
      rank_old = Kr;
      for (int i = 0; i < R; i++) begin
         if (r_idx == i) begin
            holder = o_q[i*LS +: LS];
            r_free = !rm_q[i];
            for (int j = Kr-1; j >= 0; j--) begin
               if (rpref_q[(i*Kr+j)*LS +: LS] == cand)   rank_new = j;
               if (rpref_q[(i*Kr+j)*LS +: LS] == holder) rank_old = j;
            end
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      spref_d   = spref_q;
      rpref_d   = rpref_q;
      pc_d      = pc_q;
      iter_d    = iter_q;
      timeout_d = timeout_q;
      o_d       = o_q;
      rm_d      = rm_q;
      sm_d      = sm_q;
      take      = 1'b0;
      drop      = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d   = ST_RUN;
               spref_d   = g[RW +: SW];
               rpref_d   = g[RW-1:0];
               for (int i = 0; i < S; i++) pc_d[i*PCW +: PCW] = PCW'(Ks);
               iter_d    = '0;
               timeout_d = 1'b0;
               o_d       = '0;
               rm_d      = '0;
               sm_d      = '0;
            end
         end
         ST_RUN: begin
            if (!cand_found) begin
               state_d   = ST_DONE;
               timeout_d = 1'b0;
            end else if (iter_q == IW'(MAX_ITER)) begin
               state_d   = ST_DONE;
               timeout_d = 1'b1;
            end else begin
               iter_d = iter_q + IW'(1);
               for (int i = 0; i < S; i++)
                  if (cand == LS'(i)) pc_d[i*PCW +: PCW] = pc_q[i*PCW +: PCW] - PCW'(1);
               // Out-of-range receiver: the proposal is spent with no match change.
               if (r_idx < R) begin
                  for (int i = 0; i < R; i++) begin
                     if (r_idx == i) begin
                        if (r_free) begin
                           o_d[i*LS +: LS] = cand;
                           rm_d[i]         = 1'b1;
                           take            = 1'b1;
                        end else if (rank_new < rank_old) begin
                           o_d[i*LS +: LS] = cand;
                           take            = 1'b1;
                           drop            = 1'b1;
                        end
                     end
                  end
                  for (int k = 0; k < S; k++) begin
                     if (drop && holder == LS'(k)) sm_d[k] = 1'b0;
                     if (take && cand == LS'(k))   sm_d[k] = 1'b1;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         spref_q   <= '0;
         rpref_q   <= '0;
         pc_q      <= '0;
         iter_q    <= '0;
         timeout_q <= 1'b0;
         o_q       <= '0;
         rm_q      <= '0;
         sm_q      <= '0;
      end else begin
         state_q   <= state_d;
         spref_q   <= spref_d;
         rpref_q   <= rpref_d;
         pc_q      <= pc_d;
         iter_q    <= iter_d;
         timeout_q <= timeout_d;
         o_q       <= o_d;
         rm_q      <= rm_d;
         sm_q      <= sm_d;
      end
   end

   assign busy       = (state_q == ST_RUN);
   assign done       = (state_q == ST_DONE);
   assign timeout    = timeout_q;
   assign iter_count = iter_q;
   assign o          = o_q;
   assign r_matched  = rm_q;
   assign s_matched  = sm_q;
endmodule

// File: tb/tb_stable_matching_seq.sv
// Directed bench for stable_matching_seq at S=R=Ks=Kr=3, plus a MAX_ITER=3 instance.
module tb_stable_matching_seq;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_a = 1'b0;
   logic        start_b = 1'b0;
   logic [35:0] g = '0;

   logic       busy_a, done_a, tmo_a;
   logic [3:0] it_a;
   logic [5:0] o_a;
   logic [2:0] rm_a, sm_a;
   logic       busy_b, done_b, tmo_b;
   logic [1:0] it_b;
   logic [5:0] o_b;
   logic [2:0] rm_b, sm_b;

   int checks = 0;
   int failures = 0;
   int sp[3][3];
   int rp[3][3];
   logic [35:0] g1, g3, g4;

   typedef struct {
      logic [35:0] gv;
      int          nprop;
      logic [3:0]  it;
      logic        tmo;
      logic [5:0]  o;
      logic [2:0]  rm;
      logic [2:0]  sm;
   } vec_t;
   vec_t vecs[3];

   stable_matching_seq #(.S(3), .R(3), .Ks(3), .Kr(3)) dut (
      .clk(clk), .rst_n(rst_n), .start(start_a), .g(g),
      .busy(busy_a), .done(done_a), .timeout(tmo_a), .iter_count(it_a),
      .o(o_a), .r_matched(rm_a), .s_matched(sm_a));

   stable_matching_seq #(.S(3), .R(3), .Ks(3), .Kr(3), .MAX_ITER(3)) dut_t (
      .clk(clk), .rst_n(rst_n), .start(start_b), .g(g),
      .busy(busy_b), .done(done_b), .timeout(tmo_b), .iter_count(it_b),
      .o(o_b), .r_matched(rm_b), .s_matched(sm_b));

   always #5 clk = ~clk;

   function automatic logic [35:0] build_g();
      logic [35:0] v;
      int e;
      v = '0;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            e = rp[i][j];
            v[(i*3+j)*2 +: 2] = e[1:0];
            e = sp[i][j];
            v[18 + (i*3+j)*2 +: 2] = e[1:0];
         end
      end
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pulse_start_a(input logic [35:0] gv);
      @(negedge clk);
      g = gv;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
   endtask

   task automatic wait_done_a(output int n);
      n = 0;
      while (!done_a && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic run_vec(input int k);
      int n;
      pulse_start_a(vecs[k].gv);
      chk($sformatf("v%0d busy_after_e0", k), busy_a, 1'b1);
      chk($sformatf("v%0d iter_after_e0", k), it_a, 4'd0);
      wait_done_a(n);
      chk($sformatf("v%0d done_edge", k), n, vecs[k].nprop + 1);
      chk($sformatf("v%0d busy_end", k), busy_a, 1'b0);
      chk($sformatf("v%0d iter", k), it_a, vecs[k].it);
      chk($sformatf("v%0d timeout", k), tmo_a, vecs[k].tmo);
      chk($sformatf("v%0d o", k), o_a, vecs[k].o);
      chk($sformatf("v%0d r_matched", k), rm_a, vecs[k].rm);
      chk($sformatf("v%0d s_matched", k), sm_a, vecs[k].sm);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      sp[0] = '{0, 1, 2}; sp[1] = '{0, 2, 1}; sp[2] = '{1, 0, 2};
      rp[0] = '{1, 0, 2}; rp[1] = '{0, 2, 1}; rp[2] = '{0, 1, 2};
      g1 = build_g();
      sp[0] = '{3, 3, 0}; sp[1] = '{1, 0, 2}; sp[2] = '{2, 0, 1};
      rp[0] = '{0, 1, 2}; rp[1] = '{0, 1, 2}; rp[2] = '{0, 1, 2};
      g3 = build_g();
      sp[0] = '{0, 1, 2}; sp[1] = '{0, 1, 2}; sp[2] = '{1, 2, 0};
      rp[0] = '{2, 2, 2}; rp[1] = '{0, 1, 2}; rp[2] = '{0, 1, 2};
      g4 = build_g();

      vecs[0] = '{g1, 6, 4'd6, 1'b0, 6'b10_00_01, 3'b111, 3'b111};
      vecs[1] = '{g3, 5, 4'd5, 1'b0, 6'b10_01_00, 3'b111, 3'b111};
      vecs[2] = '{g4, 5, 4'd5, 1'b0, 6'b10_01_00, 3'b111, 3'b111};

      #1;
      chk("reset_a", {busy_a, done_a, tmo_a, it_a, o_a, rm_a, sm_a}, 64'd0);
      chk("reset_b", {busy_b, done_b, tmo_b, it_b, o_b, rm_b, sm_b}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int k = 0; k < 3; k++) run_vec(k);

      // Out-of-range entries consumed without effect
      pulse_start_a(g3);
      repeat (2) @(posedge clk);
      #1;
      chk("oor_e2_iter", it_a, 4'd2);
      chk("oor_e2_rm", rm_a, 3'b000);
      @(posedge clk);
      #1;
      chk("oor_e3_sm", sm_a, 3'b001);
      chk("oor_e3_o", o_a, 6'b00_00_00);
      wait_done_a(n);

      // Both absent from r0's list: challenger rejected
      pulse_start_a(g4);
      repeat (2) @(posedge clk);
      #1;
      chk("absent_e2_o", o_a, 6'b00_00_00);
      chk("absent_e2_rm", rm_a, 3'b001);
      chk("absent_e2_sm", sm_a, 3'b001);
      wait_done_a(n);

      // MAX_ITER budget reached
      @(negedge clk);
      g = g1;
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      n = 0;
      while (!done_b && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("tmo_done_edge", n, 4);
      chk("tmo_flag", tmo_b, 1'b1);
      chk("tmo_iter", it_b, 2'd3);
      chk("tmo_o", o_b, 6'b00_00_01);
      chk("tmo_rm", rm_b, 3'b011);
      chk("tmo_sm", sm_b, 3'b011);

      // start on the edge that enters DONE is ignored
      pulse_start_a(g1);
      repeat (6) @(posedge clk);
      @(negedge clk);
      start_a = 1'b1;
      @(posedge clk);
      #1;
      chk("doneedge_done", done_a, 1'b1);
      @(negedge clk);
      start_a = 1'b0;
      @(posedge clk);
      #1;
      chk("doneedge_hold_done", done_a, 1'b1);
      chk("doneedge_hold_iter", it_a, 4'd6);

      // start during RUN ignored, g not resampled; then restart from DONE
      pulse_start_a(g1);
      @(posedge clk);
      @(negedge clk);
      g = g3;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      wait_done_a(n);
      chk("midstart_done_edge", n + 2, 7);
      chk("midstart_o", o_a, 6'b10_00_01);
      chk("midstart_iter", it_a, 4'd6);
      pulse_start_a(g4);
      chk("restart_iter0", it_a, 4'd0);
      chk("restart_busy", busy_a, 1'b1);
      wait_done_a(n);
      chk("restart_o", o_a, 6'b10_01_00);
      chk("restart_iter", it_a, 4'd5);

      // Async reset mid-run, then clean rerun
      pulse_start_a(g1);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_outputs", {busy_a, done_a, tmo_a, it_a, o_a, rm_a, sm_a}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_vec(0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
